// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a registered valid/ready output stage.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1).

module arb_mux_lane #(
  parameter int SELW = 2,
  parameter int ID   = 0
) (
  input  logic            found,
  input  logic [SELW-1:0] gnt_idx,
  input  logic            accept,
  output logic            ready
);
  assign ready = found & accept & (gnt_idx == SELW'(ID));
endmodule

module arb_mux #(
  parameter int B    = 32,
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [N-1:0]                          in_valid,
  input  logic [N*B-1:0]                        in_data,
  output logic [N-1:0]                          in_ready,
  output logic                                  out_valid,
  output logic [B-1:0]                          out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  out_sel,
  input  logic                                  out_ready
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][B-1:0] din;
  logic [SELW-1:0]     ptr;
  logic [SELW-1:0]     gnt_idx;
  logic [SELW:0]       idx;
  logic                found;
  logic                load_en;
  logic                accept;
  logic                xfer;

  assign din     = in_data;
  assign load_en = !out_valid | out_ready;
  // reset gates accept so no channel is consumed while in reset
  assign accept  = load_en & !flush & reset;
  assign xfer    = found & accept;

  // Search from ptr upward with explicit wrap; in MODE 1 ptr stays 0,
  // which turns the same search into lowest-index priority.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
      if (!found && in_valid[idx[SELW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[SELW-1:0];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    arb_mux_lane #(.SELW(SELW), .ID(i)) u_lane (
      .found   (found),
      .gnt_idx (gnt_idx),
      .accept  (accept),
      .ready   (in_ready[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= din[gnt_idx];
      out_sel   <= gnt_idx;
      if (MODE == 0)
        ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (N4 RR, N4 fixed, N3 RR) against a queue-free
// behavioural model, plus directed literal checks.

module tb_arb_mux;
  logic         clk = 1'b0;
  logic         reset, flush, out_ready;
  logic [3:0]   vld;
  logic [127:0] din;

  logic [3:0]  r0, r1;
  logic [2:0]  r2;
  logic        v0, v1, v2;
  logic [31:0] d0, d1, d2;
  logic [1:0]  s0, s1, s2;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  arb_mux #(.B(32), .N(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(vld), .in_data(din),
    .in_ready(r0), .out_valid(v0), .out_data(d0), .out_sel(s0), .out_ready(out_ready));
  arb_mux #(.B(32), .N(4), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(vld), .in_data(din),
    .in_ready(r1), .out_valid(v1), .out_data(d1), .out_sel(s1), .out_ready(out_ready));
  arb_mux #(.B(32), .N(3), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(vld[2:0]), .in_data(din[95:0]),
    .in_ready(r2), .out_valid(v2), .out_data(d2), .out_sel(s2), .out_ready(out_ready));

  // model state per instance
  int          nch[3]  = '{4, 4, 3};
  int          mmode[3] = '{0, 1, 0};
  int          mptr[3] = '{0, 0, 0};
  bit          mv[3]   = '{0, 0, 0};
  logic [31:0] md[3]   = '{0, 0, 0};
  int          ms[3]   = '{0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mgrant(input int d);
    logic [3:0] v;
    v = vld & ((nch[d] == 4) ? 4'hF : 4'h7);
    if (mmode[d] == 1) begin
      for (int i = 0; i < nch[d]; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 0; k < nch[d]; k++)
      if (v[(mptr[d] + k) % nch[d]]) return (mptr[d] + k) % nch[d];
    return -1;
  endfunction

  function automatic logic [3:0] erdy(input int d);
    int g;
    g = mgrant(d);
    if (!reset || flush || !(!mv[d] || out_ready) || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int g;
      g = mgrant(d);
      if (!reset) begin
        mv[d] <= 1'b0; md[d] <= '0; ms[d] <= 0; mptr[d] <= 0;
      end else if (flush) begin
        mv[d] <= 1'b0;
      end else if ((!mv[d] || out_ready) && g >= 0) begin
        mv[d] <= 1'b1;
        md[d] <= din[g*32 +: 32];
        ms[d] <= g;
        if (mmode[d] == 0) mptr[d] <= (g + 1) % nch[d];
      end else if (out_ready) begin
        mv[d] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [3:0] ar; logic av; logic [31:0] ad; logic [1:0] as;
        case (d)
          0:       begin ar = r0;         av = v0; ad = d0; as = s0; end
          1:       begin ar = r1;         av = v1; ad = d1; as = s1; end
          default: begin ar = {1'b0, r2}; av = v2; ad = d2; as = s2; end
        endcase
        chk($sformatf("m%0d in_ready", d), 64'(ar), 64'(erdy(d)));
        chk($sformatf("m%0d out_valid", d), 64'(av), 64'(mv[d]));
        chk($sformatf("m%0d out_data", d), 64'(ad), 64'(md[d]));
        chk($sformatf("m%0d out_sel", d), 64'(as), 64'(ms[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; vld = 4'hF;
    din = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 3; i++) begin
      step(); chk_en = 1'b1;
      chk("rst in_ready", 64'(r0), 64'h0);
      chk("rst out_valid", 64'(v0), 64'h0);
      chk("rst out_data", 64'(d0), 64'h0);
      chk("rst out_sel", 64'(s0), 64'h0);
    end
    reset = 1'b1; #1;
    chk("first grant", 64'(r0), 64'h1);

    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr sel", 64'(s0), 64'(i % 4));
      chk("rr data", 64'(d0), 64'(32'hA0 + i % 4));
    end
    step();
    chk("bp held sel", 64'(s0), 64'h2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp in_ready", 64'(r0), 64'h0);
      step();
      chk("bp data", 64'(d0), 64'hA2);
      chk("bp sel", 64'(s0), 64'h2);
    end
    out_ready = 1'b1;
    step();
    chk("bp release sel", 64'(s0), 64'h3);
    chk("bp release data", 64'(d0), 64'hA3);

    out_ready = 1'b0; flush = 1'b1;
    #1 chk("flush in_ready", 64'(r0), 64'h0);
    step();
    chk("flush out_valid", 64'(v0), 64'h0);
    flush = 1'b0; out_ready = 1'b1;
    #1 chk("post flush grant", 64'(r0), 64'h1);
    step();
    chk("post flush sel", 64'(s0), 64'h0);

    vld = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      #1 chk("fp in_ready3", 64'(r1[3]), 64'h0);
      step();
      chk("fp sel", 64'(s1), 64'h1);
      chk("fp valid", 64'(v1), 64'h1);
    end

    reset = 1'b0;
    step();
    reset = 1'b1; vld = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n3 wrap sel", 64'(s2), 64'((i % 2) ? 2 : 0));
    end

    for (int i = 0; i < 3000; i++) begin
      vld       = 4'($urandom);
      din       = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      reset     = ($urandom % 64) != 0;
      step();
    end
    reset = 1'b1; flush = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
